// File: rtl/lsu_mem_master_if.sv
// Request, response and memory-port bundle between execute, the LSU and the memory controller.
// Latency: none, wires only.
// Backpressure: valid/ready on req and resp; the memory port has no stall input.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;

    // LSU view.
    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    // Execute/writeback/controller view.
    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Data-memory initiator: byte lane steering, write masks, load extension; LSU_MISALIGN_CHECK_EN enables misalignment errors.
// Latency: mem_valid held LAT cycles after accept, response the cycle after; misaligned requests respond next cycle.
// Backpressure: one request in flight; req_ready stays low until resp_ready takes the pending response.
module lsu_mem_master #(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t         state_q, state_d;
    logic           accept;
    logic           misalign;
    logic [31:0]    req_addr_al;

    logic           wen_q;
    logic           sext_q;
    logic           err_q;
    logic [1:0]     size_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;
    logic [CW-1:0]  cnt_q;

    logic [3:0]     lane_mask;
    logic [31:0]    load_word;
    logic [31:0]    load_ext;

`ifdef LSU_MISALIGN_CHECK_EN
    // Half needs addr[0]==0, word (and size 11) needs addr[1:0]==0.
    assign misalign    = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                         (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
    assign req_addr_al = bus.req_addr;
`else
    assign misalign = 1'b0;

    // Without checking, force the low address bits to the access size.
    always_comb begin
        req_addr_al = bus.req_addr;
        if (bus.req_size == 2'b01) begin
            req_addr_al[0] = 1'b0;
        end else if (bus.req_size[1]) begin
            req_addr_al[1:0] = 2'b00;
        end
    end
`endif

    // Byte-lane enables for stores, positioned by the byte offset.
    always_comb begin
        case (size_q)
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
            default: lane_mask = 4'b1111;
        endcase
    end

    // Right-align the addressed bytes of the read word and extend them.
    always_comb begin
        load_word = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{sext_q & load_word[7]}},  load_word[7:0]};
            2'b01:   load_ext = {{16{sext_q & load_word[15]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all handshake/memory outputs; mem_* are zero outside ACCESS.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.resp_err   = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_raddr  = 32'd0;
        bus.mem_waddr  = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.mem_wmask  = 8'd0;
        case (state_q)
            IDLE: begin
                bus.req_ready = rst_n;
                if (bus.req_valid && rst_n) begin
                    accept  = 1'b1;
                    state_d = misalign ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_valid = 1'b1;
                bus.mem_wen   = wen_q;
                bus.mem_raddr = {addr_q[31:2], 2'b00};
                bus.mem_waddr = {addr_q[31:2], 2'b00};
                if (wen_q) begin
                    bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
                    bus.mem_wmask = {4'b0000, lane_mask};
                end
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, access countdown and load-data capture on the last access cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= '0;
        end else if (accept) begin
            wen_q   <= bus.req_wen;
            sext_q  <= bus.req_sext;
            err_q   <= misalign;
            size_q  <= bus.req_size;
            addr_q  <= req_addr_al;
            wdata_q <= bus.req_wdata;
            rdata_q <= 32'd0;
            cnt_q   <= CW'(LAT - 1);
        end else if (state_q == ACCESS) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (!wen_q) begin
                rdata_q <= load_ext;
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
`timescale 1ns/1ps
module tb_lsu_mem_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_master_if bus0();
    lsu_mem_master_if bus1();

    lsu_mem_master #(.LAT(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    lsu_mem_master #(.LAT(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    // Drive side, one slot per DUT (0: LAT=1, 1: LAT=3).
    logic        d_valid [2];
    logic        d_wen   [2];
    logic        d_sext  [2];
    logic        d_rr    [2];
    logic [1:0]  d_size  [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_mrd   [2];

    // Observed outputs.
    logic        o_rdy [2], o_rv [2], o_err [2], o_mv [2], o_mwen [2];
    logic [31:0] o_rd [2], o_ra [2], o_wa [2], o_wd [2];
    logic [7:0]  o_wm [2];

    assign bus0.req_valid = d_valid[0];  assign bus1.req_valid = d_valid[1];
    assign bus0.req_wen   = d_wen[0];    assign bus1.req_wen   = d_wen[1];
    assign bus0.req_sext  = d_sext[0];   assign bus1.req_sext  = d_sext[1];
    assign bus0.req_size  = d_size[0];   assign bus1.req_size  = d_size[1];
    assign bus0.req_addr  = d_addr[0];   assign bus1.req_addr  = d_addr[1];
    assign bus0.req_wdata = d_wdata[0];  assign bus1.req_wdata = d_wdata[1];
    assign bus0.resp_ready = d_rr[0];    assign bus1.resp_ready = d_rr[1];
    assign bus0.mem_rdata = d_mrd[0];    assign bus1.mem_rdata = d_mrd[1];

    assign o_rdy[0] = bus0.req_ready;    assign o_rdy[1] = bus1.req_ready;
    assign o_rv[0]  = bus0.resp_valid;   assign o_rv[1]  = bus1.resp_valid;
    assign o_err[0] = bus0.resp_err;     assign o_err[1] = bus1.resp_err;
    assign o_rd[0]  = bus0.resp_rdata;   assign o_rd[1]  = bus1.resp_rdata;
    assign o_mv[0]  = bus0.mem_valid;    assign o_mv[1]  = bus1.mem_valid;
    assign o_mwen[0] = bus0.mem_wen;     assign o_mwen[1] = bus1.mem_wen;
    assign o_ra[0]  = bus0.mem_raddr;    assign o_ra[1]  = bus1.mem_raddr;
    assign o_wa[0]  = bus0.mem_waddr;    assign o_wa[1]  = bus1.mem_waddr;
    assign o_wd[0]  = bus0.mem_wdata;    assign o_wd[1]  = bus1.mem_wdata;
    assign o_wm[0]  = bus0.mem_wmask;    assign o_wm[1]  = bus1.mem_wmask;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-timeline model ----------------
    // A request accepted at an edge occupies "age" 1.. after it: memory is
    // driven for ages 1..LAT (never if misaligned), the response is offered
    // from age LAT+1 (age 1 if misaligned) until taken.
    int          lat    [2] = '{1, 3};
    bit          pend   [2] = '{0, 0};
    int          age    [2];
    bit          m_err  [2];
    bit          m_wen  [2];
    bit          m_sext [2];
    int          m_bytes[2];
    logic [31:0] m_off  [2];
    logic [31:0] m_word [2];
    logic [31:0] m_wd   [2];
    logic [7:0]  m_wm   [2];
    logic [31:0] m_rdata[2];

    function automatic logic [31:0] extract(input logic [31:0] rd, input logic [31:0] off,
                                            input int bytes, input bit sext);
        logic [31:0] w;
        logic [31:0] v;
        w = rd >> (8 * off);
        if (bytes == 1) begin
            v = w % 256;
            if (sext && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (bytes == 2) begin
            v = w % 65536;
            if (sext && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_step(input int k);
        string       p;
        bit          mv, rv;
        int          rs;
        logic [31:0] a, tmp;
        p  = $sformatf("dut%0d ", k);
        rs = m_err[k] ? 1 : lat[k] + 1;
        mv = pend[k] && !m_err[k] && age[k] >= 1 && age[k] <= lat[k];
        rv = pend[k] && age[k] >= rs;
        chk({p, "req_ready"}, o_rdy[k], rst_n && !pend[k]);
        chk({p, "mem_valid"}, o_mv[k], mv);
        chk({p, "mem_wen"},   o_mwen[k], mv ? m_wen[k] : 1'b0);
        chk({p, "mem_raddr"}, o_ra[k], mv ? m_word[k] : 32'd0);
        chk({p, "mem_waddr"}, o_wa[k], mv ? m_word[k] : 32'd0);
        chk({p, "mem_wdata"}, o_wd[k], mv ? m_wd[k] : 32'd0);
        chk({p, "mem_wmask"}, o_wm[k], mv ? m_wm[k] : 8'd0);
        chk({p, "resp_valid"}, o_rv[k], rv);
        if (rv) begin
            chk({p, "resp_rdata"}, o_rd[k], m_rdata[k]);
            chk({p, "resp_err"},   o_err[k], m_err[k]);
        end
        // advance to the next edge
        if (!rst_n) begin
            pend[k] = 0;
        end else if (pend[k]) begin
            if (!m_err[k] && !m_wen[k] && age[k] == lat[k])
                m_rdata[k] = extract(d_mrd[k], m_off[k], m_bytes[k], m_sext[k]);
            if (rv && d_rr[k]) pend[k] = 0;
            else               age[k]++;
        end else if (d_valid[k]) begin
            a = d_addr[k];
            m_bytes[k] = (d_size[k] == 2'd0) ? 1 : (d_size[k] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_CHECK_EN
            m_err[k] = (a % m_bytes[k]) != 0;
`else
            m_err[k] = 0;
            a = a - (a % m_bytes[k]);
`endif
            m_off[k]  = a % 4;
            m_word[k] = a - m_off[k];
            m_wen[k]  = d_wen[k];
            m_sext[k] = d_sext[k];
            m_wd[k]   = d_wen[k] ? (d_wdata[k] << (8 * m_off[k])) : 32'd0;
            tmp       = ((32'd1 << m_bytes[k]) - 32'd1) << m_off[k];
            m_wm[k]   = d_wen[k] ? tmp[7:0] : 8'd0;
            m_rdata[k] = 32'd0;
            pend[k]   = 1;
            age[k]    = 1;
        end
    endtask

    // Compare process: every cycle, both DUTs, sampled at the falling edge.
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic do_req(input int k, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sext, input logic [31:0] mrd);
        int n;
        d_wen[k] = wen; d_addr[k] = addr; d_wdata[k] = wdata;
        d_size[k] = size; d_sext[k] = sext; d_mrd[k] = mrd;
        d_valid[k] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_rdy[k] && n < 20);
        chk($sformatf("dut%0d req accepted", k), o_rdy[k], 1'b1);
        @(posedge clk); #1;
        d_valid[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, input string tag, input int exp_lat, input int exp_mv,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wd, input logic [7:0] exp_wm,
                             input logic exp_wen, input logic [31:0] exp_rd, input logic exp_err);
        int          n;
        int          mvc;
        logic [31:0] ra, wa, wd;
        logic [7:0]  wm;
        logic        we;
        n = 0; mvc = 0; ra = 0; wa = 0; wd = 0; wm = 0; we = 0;
        do begin
            @(negedge clk);
            n++;
            if (o_mv[k]) begin
                mvc++;
                ra = o_ra[k]; wa = o_wa[k]; wd = o_wd[k]; wm = o_wm[k]; we = o_mwen[k];
            end
        end while (!o_rv[k] && n < 50);
        chk({tag, " resp cycle"}, n, exp_lat);
        chk({tag, " mem_valid cycles"}, mvc, exp_mv);
        if (exp_mv > 0) begin
            chk({tag, " raddr"}, ra, exp_addr);
            chk({tag, " waddr"}, wa, exp_addr);
            chk({tag, " wdata"}, wd, exp_wd);
            chk({tag, " wmask"}, wm, exp_wm);
            chk({tag, " wen"},   we, exp_wen);
        end
        chk({tag, " rdata"}, o_rd[k], exp_rd);
        chk({tag, " err"},   o_err[k], exp_err);
        if (d_rr[k]) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            d_valid[k] = 0; d_wen[k] = 0; d_sext[k] = 0; d_rr[k] = 1;
            d_size[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; d_mrd[k] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset req_ready",  o_rdy[k], 1'b0);
            chk("reset mem_valid",  o_mv[k],  1'b0);
            chk("reset mem_wen",    o_mwen[k], 1'b0);
            chk("reset mem_raddr",  o_ra[k],  32'd0);
            chk("reset mem_waddr",  o_wa[k],  32'd0);
            chk("reset mem_wdata",  o_wd[k],  32'd0);
            chk("reset mem_wmask",  o_wm[k],  8'd0);
            chk("reset resp_valid", o_rv[k],  1'b0);
            chk("reset resp_rdata", o_rd[k],  32'd0);
            chk("reset resp_err",   o_err[k], 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LAT=1 loads and stores
        do_req(0, 0, 32'h8000_0004, 32'h0, 2'd2, 0, 32'hDEAD_BEEF);
        wait_resp(0, "ld word", 2, 1, 32'h8000_0004, 32'h0, 8'h00, 0, 32'hDEAD_BEEF, 0);
        do_req(0, 0, 32'h8000_0003, 32'h0, 2'd0, 1, 32'h8500_1122);
        wait_resp(0, "ld byte sext", 2, 1, 32'h8000_0000, 32'h0, 8'h00, 0, 32'hFFFF_FF85, 0);
        do_req(0, 0, 32'h8000_0003, 32'h0, 2'd0, 0, 32'h8500_1122);
        wait_resp(0, "ld byte zext", 2, 1, 32'h8000_0000, 32'h0, 8'h00, 0, 32'h0000_0085, 0);
        do_req(0, 1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 0, 32'h0);
        wait_resp(0, "st half", 2, 1, 32'h8000_0000, 32'hABCD_0000, 8'h0C, 1, 32'h0, 0);
        do_req(0, 0, 32'h8000_0002, 32'h0, 2'd1, 1, 32'h8001_7FFF);
        wait_resp(0, "ld half sext", 2, 1, 32'h8000_0000, 32'h0, 8'h00, 0, 32'hFFFF_8001, 0);
        do_req(0, 0, 32'h8000_0002, 32'h0, 2'd1, 0, 32'h8001_7FFF);
        wait_resp(0, "ld half zext", 2, 1, 32'h8000_0000, 32'h0, 8'h00, 0, 32'h0000_8001, 0);
        do_req(0, 1, 32'h8000_0001, 32'h1234_565A, 2'd0, 0, 32'h0);
        wait_resp(0, "st byte", 2, 1, 32'h8000_0000, 32'h3456_5A00, 8'h02, 1, 32'h0, 0);
        do_req(0, 0, 32'h8000_0008, 32'h0, 2'd3, 1, 32'h0BAD_F00D);
        wait_resp(0, "ld size3", 2, 1, 32'h8000_0008, 32'h0, 8'h00, 0, 32'h0BAD_F00D, 0);

        // misaligned accesses
        do_req(0, 0, 32'h8000_0001, 32'h0, 2'd2, 0, 32'h1234_5678);
`ifdef LSU_MISALIGN_CHECK_EN
        wait_resp(0, "misal word", 1, 0, 32'h0, 32'h0, 8'h00, 0, 32'h0, 1);
`else
        wait_resp(0, "misal word", 2, 1, 32'h8000_0000, 32'h0, 8'h00, 0, 32'h1234_5678, 0);
`endif
        do_req(0, 0, 32'h8000_0003, 32'h0, 2'd1, 0, 32'hA5A5_1234);
`ifdef LSU_MISALIGN_CHECK_EN
        wait_resp(0, "misal half", 1, 0, 32'h0, 32'h0, 8'h00, 0, 32'h0, 1);
`else
        wait_resp(0, "misal half", 2, 1, 32'h8000_0000, 32'h0, 8'h00, 0, 32'h0000_A5A5, 0);
`endif

        // LAT=3 with the response held off for 5 cycles and a competing request
        d_rr[1] = 1'b0;
        do_req(1, 0, 32'h0000_0010, 32'h0, 2'd2, 0, 32'hCAFE_F00D);
        wait_resp(1, "stall ld", 4, 3, 32'h0000_0010, 32'h0, 8'h00, 0, 32'hCAFE_F00D, 0);
        @(posedge clk); #1;
        d_valid[1] = 1'b1; d_wen[1] = 1'b1; d_addr[1] = 32'h40; d_wdata[1] = 32'h5555_AAAA; d_size[1] = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall resp_valid", o_rv[1], 1'b1);
            chk("stall resp_rdata", o_rd[1], 32'hCAFE_F00D);
            chk("stall req_ready",  o_rdy[1], 1'b0);
            chk("stall mem_valid",  o_mv[1], 1'b0);
            @(posedge clk); #1;
        end
        d_valid[1] = 1'b0;
        d_rr[1] = 1'b1;
        @(negedge clk);
        chk("release resp_valid", o_rv[1], 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after resp resp_valid", o_rv[1], 1'b0);
        chk("after resp req_ready",  o_rdy[1], 1'b1);
        chk("after resp mem_valid",  o_mv[1], 1'b0);
        @(posedge clk); #1;

        // reset during the second access cycle of a LAT=3 store
        do_req(1, 1, 32'h0000_0020, 32'h1122_3344, 2'd2, 0, 32'h0);
        @(negedge clk);
        chk("rst acc1 mem_valid", o_mv[1], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst acc2 mem_valid", o_mv[1], 1'b1);
        chk("rst acc2 req_ready", o_rdy[1], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst after mem_valid",  o_mv[1], 1'b0);
        chk("rst after resp_valid", o_rv[1], 1'b0);
        chk("rst after req_ready",  o_rdy[1], 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst release req_ready", o_rdy[1], 1'b1);
        chk("rst release mem_valid", o_mv[1], 1'b0);
        @(posedge clk); #1;

        do_req(1, 1, 32'h0000_0023, 32'h0000_00EE, 2'd0, 0, 32'h0);
        wait_resp(1, "post-rst st byte", 4, 3, 32'h0000_0020, 32'hEE00_0000, 8'h08, 1, 32'h0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
